pipectrl: RTL and testbench
===========================

# pipectrl

Pipeline sequencing controller for the semiMIPS five-stage core. It drives the write-enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and resolves load-use hazards, taken-branch flushes and memory wait-states. It also runs the end-of-program drain: after the Fin instruction is decoded, it stops fetch, lets the pipeline empty until Fin leaves the write-back stage, then halts the core.

## Interface
- DRAIN_MAX, 8: maximum cycles spent in DRAIN before a forced halt.
- CNT_W, 16: width of performance counters (used only with PIPECTRL_PERF_EN).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register indices of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads rs / rt.
- id_fin  in  1  the ID instruction is Fin.
- ex_memread  in  1  the EX instruction is a load.
- ex_rt  in  5  load destination register in EX.
- ex_branch_taken  in  1  the branch resolved in EX is taken.
- mem_wait  in  1  the data memory is not ready this cycle.
- wb_fin  in  1  Fin flag at the MEM/WB register output.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads zeroed controls (RegWr=0, MemtoReg=0, Fin=0).
- pipe_we  out  1  write enable for ID/EX, EX/MEM and MEM/WB.
- halted  out  1  the core is stopped.
- drain_err  out  1  DRAIN timed out; sticky until reset.

## Operation
- States: RUN, DRAIN, HALT. Reset enters RUN with the drain counter at 0 and drain_err=0.
- Load-use hazard `lu`: ex_memread && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
- Output priority in RUN, highest first:
  1. mem_wait: pc_we=0, ifid_we=0, pipe_we=0, no flush, no bubble. The whole pipeline freezes.
  2. ex_branch_taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, pipe_we=1.
  3. lu: pc_we=0, ifid_we=0, idex_bubble=1, pipe_we=1. This is a one-cycle stall.
  4. Otherwise: pc_we=ifid_we=pipe_we=1, no flush, no bubble.
- RUN to DRAIN when id_fin=1 and neither mem_wait, ex_branch_taken nor lu is active. A taken branch discards the Fin, and the controller stays in RUN.
- DRAIN:
  - pc_we=0, ifid_we=0, idex_bubble=1, pipe_we=!mem_wait.
  - The drain counter increments only on cycles where mem_wait=0.
  - wb_fin=1 moves to HALT.
  - If the counter reaches DRAIN_MAX first, go to HALT and set drain_err=1.
  - If wb_fin=1 and the counter reaches DRAIN_MAX in the same cycle, go to HALT with drain_err=0.
- HALT: pc_we=ifid_we=pipe_we=0, halted=1. All inputs are ignored. Only rst leaves HALT.
- ex_rt=0 never triggers a stall, because $zero is never written.

## Timing
- Enable, flush and bubble outputs are combinational from the current state and same-cycle inputs. They take effect at the next clk edge.
- halted and drain_err are registered.
- State, drain counter and drain_err update at the clk edge.
- While rst=1: pc_we=0, ifid_we=0, pipe_we=0, ifid_flush=1, idex_bubble=1, halted=0, drain_err=0. Reset applied mid-DRAIN or in HALT returns to RUN on the following edge.
- Load-use stall lasts exactly 1 cycle, because the load advances to MEM on the next edge.
- Branch flush costs 2 bubbles.
- Minimum drain is 3 cycles from the RUN to DRAIN edge to wb_fin (Fin travels EX, MEM, WB). halted rises on the edge after wb_fin is seen.

## Configuration
- PIPECTRL_PERF_EN defined:
  - Adds outputs stall_cnt, flush_cnt and wait_cnt (each CNT_W wide).
  - Each counts cycles of load-use stall, branch flush and mem_wait respectively, in RUN only.
  - All three reset to 0, saturate at all-ones, and freeze in HALT.
- PIPECTRL_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package semimips_pkg holds:
  - the pipe_state_t enum (RUN, DRAIN, HALT);
  - REG_IDX_W=5;
  - the NOP encoding used by IF/ID flush.
- Sub-module pipectrl_hazard: combinational load-use comparator producing `lu`. It is reused later by the forwarding unit.

## Test plan
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 -> for one cycle pc_we=0, ifid_we=0, idex_bubble=1, pipe_we=1. Next cycle (ex_memread=0) -> all enables 1.
- Zero register: same as above but ex_rt=0 -> no stall.
- Branch + hazard: ex_branch_taken=1 together with lu=1 -> ifid_flush=1, idex_bubble=1, pc_we=1.
- Fin drain: id_fin=1 in RUN -> DRAIN. wb_fin=1 three cycles later -> halted=1 on the next edge, pc_we=0 thereafter, drain_err=0.
- Drain timeout: DRAIN_MAX=8, wb_fin held at 0 -> HALT after 8 non-wait cycles with drain_err=1. Then rst=1 for one cycle -> RUN, halted=0, drain_err=0.
- Memory wait: mem_wait=1 for 3 cycles during DRAIN -> pipe_we=0 on those cycles and the drain counter holds its value.

Source files
------------

// File: rtl/semimips_pkg.sv
// Shared semiMIPS definitions: pipeline controller states, register index width,
// and the instruction word that IF/ID loads when it is flushed.
package semimips_pkg;

    localparam int REG_IDX_W = 5;

    // sll $0,$0,0 -- the canonical MIPS no-op
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipectrl_if.sv
// Controller <-> datapath hazard/status inputs and pipeline-register controls.
// Performance counter signals exist only when PIPECTRL_PERF_EN is defined.
interface pipectrl_if
    import semimips_pkg::*;
`ifdef PIPECTRL_PERF_EN
    #(parameter int CNT_W = 16)
`endif
    ;

    logic [REG_IDX_W-1:0] id_rs;
    logic [REG_IDX_W-1:0] id_rt;
    logic                 id_uses_rs;
    logic                 id_uses_rt;
    logic                 id_fin;
    logic                 ex_memread;
    logic [REG_IDX_W-1:0] ex_rt;
    logic                 ex_branch_taken;
    logic                 mem_wait;
    logic                 wb_fin;

    logic                 pc_we;
    logic                 ifid_we;
    logic                 ifid_flush;
    logic                 idex_bubble;
    logic                 pipe_we;
    logic                 halted;
    logic                 drain_err;

`ifdef PIPECTRL_PERF_EN
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;
    logic [CNT_W-1:0]     wait_cnt;
`endif

    // master: the controller; slave: the datapath it steers
    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_fin,
               ex_memread, ex_rt, ex_branch_taken, mem_wait, wb_fin,
        output pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, halted, drain_err
`ifdef PIPECTRL_PERF_EN
        , output stall_cnt, flush_cnt, wait_cnt
`endif
    );

    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_fin,
               ex_memread, ex_rt, ex_branch_taken, mem_wait, wb_fin,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, halted, drain_err
`ifdef PIPECTRL_PERF_EN
        , input stall_cnt, flush_cnt, wait_cnt
`endif
    );

endinterface

// File: rtl/pipectrl_hazard.sv
// Load-use hazard detector: the EX load writes a register the ID instruction reads.
// Purely combinational; also shared with the forwarding unit.
module pipectrl_hazard
    import semimips_pkg::*;
(
    input  logic                 i_ex_memread,
    input  logic [REG_IDX_W-1:0] i_ex_rt,
    input  logic [REG_IDX_W-1:0] i_id_rs,
    input  logic [REG_IDX_W-1:0] i_id_rt,
    input  logic                 i_id_uses_rs,
    input  logic                 i_id_uses_rt,
    output logic                 o_lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_id_uses_rs && (i_id_rs == i_ex_rt);
    assign w_rt_hit = i_id_uses_rt && (i_id_rt == i_ex_rt);

    // $zero is never written, so a load targeting it cannot create a dependency
    assign o_lu = i_ex_memread && (i_ex_rt != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipectrl.sv
// semiMIPS pipeline sequencer: stalls, flushes, mem wait freeze and Fin drain/halt.
// Optional PIPECTRL_PERF_EN adds saturating stall/flush/wait cycle counters.
module pipectrl
    import semimips_pkg::*;
#(
    parameter int DRAIN_MAX = 8
`ifdef PIPECTRL_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic      clk,
    input  logic      rst,
    pipectrl_if.master bus
);

    localparam int                DCNT_W     = $clog2(DRAIN_MAX + 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);

    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic [DCNT_W-1:0] r_drain_cnt;
    logic              r_halted;
    logic              r_drain_err;

    logic w_lu;
    logic w_timeout;
    logic w_pc_we, w_ifid_we, w_ifid_flush, w_idex_bubble, w_pipe_we;

    pipectrl_hazard u_hazard (
        .i_ex_memread (bus.ex_memread),
        .i_ex_rt      (bus.ex_rt),
        .i_id_rs      (bus.id_rs),
        .i_id_rt      (bus.id_rt),
        .i_id_uses_rs (bus.id_uses_rs),
        .i_id_uses_rt (bus.id_uses_rt),
        .o_lu         (w_lu)
    );

    // Last allowed drain cycle that actually advances the pipeline
    assign w_timeout = (r_drain_cnt == DRAIN_LAST) && !bus.mem_wait;

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (bus.id_fin && !bus.mem_wait && !bus.ex_branch_taken && !w_lu)
                         w_state_nxt = DRAIN;
            DRAIN:   if (bus.wb_fin || w_timeout)
                         w_state_nxt = HALT;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_pc_we       = 1'b0;
        w_ifid_we     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_we     = 1'b0;
        if (rst) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.mem_wait) begin
                        w_pipe_we = 1'b0;
                    end else if (bus.ex_branch_taken) begin
                        w_pc_we       = 1'b1;
                        w_ifid_we     = 1'b1;
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_pipe_we     = 1'b1;
                    end else if (w_lu) begin
                        w_idex_bubble = 1'b1;
                        w_pipe_we     = 1'b1;
                    end else begin
                        w_pc_we   = 1'b1;
                        w_ifid_we = 1'b1;
                        w_pipe_we = 1'b1;
                    end
                end
                DRAIN: begin
                    w_idex_bubble = 1'b1;
                    w_pipe_we     = !bus.mem_wait;
                end
                default: w_pipe_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
            r_drain_err <= 1'b0;
        end else begin
            r_halted <= (w_state_nxt == HALT);
            if (r_state == DRAIN) begin
                if (!bus.mem_wait) r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end
            // A Fin arriving on the timeout cycle still counts as a clean drain
            if (r_state == DRAIN && w_timeout && !bus.wb_fin)
                r_drain_err <= 1'b1;
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.ifid_we     = w_ifid_we;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.pipe_we     = w_pipe_we;
    assign bus.halted      = r_halted && !rst;
    assign bus.drain_err   = r_drain_err && !rst;

`ifdef PIPECTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else if (r_state == RUN) begin
            if (bus.mem_wait) begin
                if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 1'b1;
            end else if (bus.ex_branch_taken) begin
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            end else if (w_lu) begin
                if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
    assign bus.wait_cnt  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_pipectrl.sv
// Self-checking bench for pipectrl: per-cycle expected control vectors are queued
// as stimulus is applied and compared against the DUT at the following negedge.
module tb_pipectrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef PIPECTRL_PERF_EN
    pipectrl_if #(.CNT_W(16)) bus ();
    pipectrl #(.DRAIN_MAX(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    pipectrl_if bus ();
    pipectrl #(.DRAIN_MAX(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct packed {
        logic       rst;
        logic       ex_memread;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       id_fin;
        logic       br;
        logic       mem_wait;
        logic       wb_fin;
    } in_t;

    // {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, halted, drain_err}
    typedef logic [6:0] out_t;
    localparam out_t O_RST   = 7'b00110_00;
    localparam out_t O_RUN   = 7'b11001_00;
    localparam out_t O_LU    = 7'b00011_00;
    localparam out_t O_BR    = 7'b11111_00;
    localparam out_t O_WAIT  = 7'b00000_00;
    localparam out_t O_DRN   = 7'b00011_00;
    localparam out_t O_DRNW  = 7'b00010_00;
    localparam out_t O_HALT  = 7'b00000_10;
    localparam out_t O_HALTE = 7'b00000_11;

    out_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic in_t idle();
        in_t v = '0;
        return v;
    endfunction

    function automatic in_t lu_rs(input logic [4:0] r);
        in_t v = idle();
        v.ex_memread = 1'b1;
        v.ex_rt      = r;
        v.id_rs      = r;
        v.uses_rs    = 1'b1;
        return v;
    endfunction

    function automatic in_t with_fin(input in_t b);
        in_t v = b;
        v.id_fin = 1'b1;
        return v;
    endfunction

    function automatic in_t with_wait(input in_t b);
        in_t v = b;
        v.mem_wait = 1'b1;
        return v;
    endfunction

    function automatic in_t with_br(input in_t b);
        in_t v = b;
        v.br = 1'b1;
        return v;
    endfunction

    function automatic in_t with_wbfin(input in_t b);
        in_t v = b;
        v.wb_fin = 1'b1;
        return v;
    endfunction

    function automatic in_t with_rst(input in_t b);
        in_t v = b;
        v.rst = 1'b1;
        return v;
    endfunction

    task automatic drive(input in_t v, input out_t e);
        rst                 = v.rst;
        bus.ex_memread      = v.ex_memread;
        bus.ex_rt           = v.ex_rt;
        bus.id_rs           = v.id_rs;
        bus.id_rt           = v.id_rt;
        bus.id_uses_rs      = v.uses_rs;
        bus.id_uses_rt      = v.uses_rt;
        bus.id_fin          = v.id_fin;
        bus.ex_branch_taken = v.br;
        bus.mem_wait        = v.mem_wait;
        bus.wb_fin          = v.wb_fin;
        sb.push_back(e);
    endtask

    function automatic out_t sample();
        return {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble,
                bus.pipe_we, bus.halted, bus.drain_err};
    endfunction

    task automatic test_reset();
        in_t  st[$];
        out_t got, e;
        st.push_back(with_rst(idle()));
        st.push_back(with_rst(with_fin(with_br(lu_rs(5'd3)))));
        st.push_back(with_rst(with_wait(idle())));
        foreach (st[i]) begin
            drive(st[i], O_RST);
            @(negedge clk);
            got = sample();
            e   = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        in_t  st[$];
        out_t ex[$];
        out_t got, e;
        in_t  v;
        st.push_back(lu_rs(5'd5));  ex.push_back(O_LU);
        st.push_back(idle());       ex.push_back(O_RUN);
        v = idle(); v.ex_memread = 1'b1; v.ex_rt = 5'd7; v.id_rt = 5'd7; v.uses_rt = 1'b1;
        st.push_back(v);            ex.push_back(O_LU);
        v.uses_rt = 1'b0;
        st.push_back(v);            ex.push_back(O_RUN);
        v = lu_rs(5'd9); v.ex_memread = 1'b0;
        st.push_back(v);            ex.push_back(O_RUN);
        v = lu_rs(5'd9); v.id_rs = 5'd8;
        st.push_back(v);            ex.push_back(O_RUN);
        st.push_back(lu_rs(5'd0));  ex.push_back(O_RUN);
        v = idle(); v.ex_memread = 1'b1; v.uses_rt = 1'b1;
        st.push_back(v);            ex.push_back(O_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = sample();
            e   = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL load_use step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_priority();
        in_t  st[$];
        out_t ex[$];
        out_t got, e;
        st.push_back(with_br(idle()));                  ex.push_back(O_BR);
        st.push_back(with_br(lu_rs(5'd4)));             ex.push_back(O_BR);
        st.push_back(with_wait(with_br(lu_rs(5'd4))));  ex.push_back(O_WAIT);
        st.push_back(with_wait(lu_rs(5'd4)));           ex.push_back(O_WAIT);
        st.push_back(with_fin(lu_rs(5'd4)));            ex.push_back(O_LU);
        st.push_back(with_fin(with_br(idle())));        ex.push_back(O_BR);
        st.push_back(with_fin(with_wait(idle())));      ex.push_back(O_WAIT);
        st.push_back(idle());                           ex.push_back(O_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = sample();
            e   = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL branch_priority step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        in_t  st[$];
        out_t ex[$];
        out_t got, e;
        st.push_back(with_br(idle()));   ex.push_back(O_BR);
        st.push_back(with_br(idle()));   ex.push_back(O_BR);
        st.push_back(lu_rs(5'd6));       ex.push_back(O_LU);
        st.push_back(lu_rs(5'd12));      ex.push_back(O_LU);
        st.push_back(with_br(idle()));   ex.push_back(O_BR);
        st.push_back(lu_rs(5'd31));      ex.push_back(O_LU);
        st.push_back(idle());            ex.push_back(O_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = sample();
            e   = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fin_drain();
        in_t  st[$];
        out_t ex[$];
        out_t got, e;
        st.push_back(with_fin(idle()));       ex.push_back(O_RUN);
        st.push_back(idle());                 ex.push_back(O_DRN);
        st.push_back(idle());                 ex.push_back(O_DRN);
        st.push_back(with_wbfin(idle()));     ex.push_back(O_DRN);
        st.push_back(idle());                 ex.push_back(O_HALT);
        st.push_back(with_br(with_fin(lu_rs(5'd2)))); ex.push_back(O_HALT);
        st.push_back(with_wait(with_wbfin(idle())));  ex.push_back(O_HALT);
        st.push_back(with_rst(idle()));       ex.push_back(O_RST);
        st.push_back(idle());                 ex.push_back(O_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = sample();
            e   = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL fin_drain step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drain_timeout();
        in_t  st[$];
        out_t ex[$];
        out_t got, e;
        st.push_back(with_fin(idle()));   ex.push_back(O_RUN);
        for (int k = 0; k < 8; k++) begin
            st.push_back(idle());         ex.push_back(O_DRN);
        end
        st.push_back(with_wbfin(idle())); ex.push_back(O_HALTE);
        st.push_back(idle());             ex.push_back(O_HALTE);
        st.push_back(with_rst(idle()));   ex.push_back(O_RST);
        st.push_back(idle());             ex.push_back(O_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = sample();
            e   = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL drain_timeout step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drain_mem_wait();
        in_t  st[$];
        out_t ex[$];
        out_t got, e;
        st.push_back(with_fin(idle()));    ex.push_back(O_RUN);
        st.push_back(idle());              ex.push_back(O_DRN);
        st.push_back(idle());              ex.push_back(O_DRN);
        for (int k = 0; k < 3; k++) begin
            st.push_back(with_wait(idle())); ex.push_back(O_DRNW);
        end
        // counter held at 2, so six more advancing cycles are needed to time out
        for (int k = 0; k < 6; k++) begin
            st.push_back(idle());          ex.push_back(O_DRN);
        end
        st.push_back(idle());              ex.push_back(O_HALTE);
        st.push_back(with_rst(idle()));    ex.push_back(O_RST);
        st.push_back(idle());              ex.push_back(O_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = sample();
            e   = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL drain_mem_wait step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drain_same_cycle();
        in_t  st[$];
        out_t ex[$];
        out_t got, e;
        st.push_back(with_fin(idle()));   ex.push_back(O_RUN);
        for (int k = 0; k < 7; k++) begin
            st.push_back(idle());         ex.push_back(O_DRN);
        end
        st.push_back(with_wbfin(idle())); ex.push_back(O_DRN);
        st.push_back(idle());             ex.push_back(O_HALT);
        st.push_back(with_rst(idle()));   ex.push_back(O_RST);
        st.push_back(idle());             ex.push_back(O_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = sample();
            e   = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL drain_same_cycle step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_drain();
        in_t  st[$];
        out_t ex[$];
        out_t got, e;
        st.push_back(with_fin(idle()));  ex.push_back(O_RUN);
        st.push_back(idle());            ex.push_back(O_DRN);
        st.push_back(with_rst(idle()));  ex.push_back(O_RST);
        st.push_back(idle());            ex.push_back(O_RUN);
        st.push_back(lu_rs(5'd1));       ex.push_back(O_LU);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = sample();
            e   = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid_drain step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        drive(with_rst(idle()), O_RST);
        void'(sb.pop_front());
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch_priority();
        test_back_to_back();
        test_fin_drain();
        test_drain_timeout();
        test_drain_mem_wait();
        test_drain_same_cycle();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
